fbox_issue_ctrl: RTL and testbench

//  Initiator side of the mkFBox_Core request/response interface. Runs the FBox

---
 rtl/fbox_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fbox_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbox_issue_ctrl.sv
// Initiator side of the mkFBox_Core request/response interface: runs the FBox reset
// handshake, then issues one FP command at a time and returns its result or a timeout.
module fbox_issue_ctrl #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             fbox_reinit,
  output logic             init_done,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_opcode,
  input  logic [6:0]       cmd_f7,
  input  logic [2:0]       cmd_rm,
  input  logic [4:0]       cmd_rs2,
  input  logic [63:0]      cmd_v1,
  input  logic [63:0]      cmd_v2,
  input  logic [63:0]      cmd_v3,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             EN_server_reset_request_put,
  input  logic             RDY_server_reset_request_put,
  output logic             EN_server_reset_response_get,
  input  logic             RDY_server_reset_response_get,
  output logic             EN_req,
  output logic [6:0]       req_opcode,
  output logic [6:0]       req_f7,
  output logic [2:0]       req_rm,
  output logic [4:0]       req_rs2,
  output logic [63:0]      req_v1,
  output logic [63:0]      req_v2,
  output logic [63:0]      req_v3,
  input  logic             valid,
  input  logic [63:0]      word_fst,
  input  logic [4:0]       word_snd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [4:0]       rsp_fflags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] stray_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RST_REQ = 3'd0,
    S_RST_RSP = 3'd1,
    S_IDLE    = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [6:0]       req_opcode_q, req_opcode_d;
  logic [6:0]       req_f7_q, req_f7_d;
  logic [2:0]       req_rm_q, req_rm_d;
  logic [4:0]       req_rs2_q, req_rs2_d;
  logic [63:0]      req_v1_q, req_v1_d;
  logic [63:0]      req_v2_q, req_v2_d;
  logic [63:0]      req_v3_q, req_v3_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_fflags_q, rsp_fflags_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0] stray_q, stray_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_opcode_d  = req_opcode_q;
    req_f7_d      = req_f7_q;
    req_rm_d      = req_rm_q;
    req_rs2_d     = req_rs2_q;
    req_v1_d      = req_v1_q;
    req_v2_d      = req_v2_q;
    req_v3_d      = req_v3_q;
    tag_d         = tag_q;
    rsp_data_d    = rsp_data_q;
    rsp_fflags_d  = rsp_fflags_q;
    rsp_timeout_d = rsp_timeout_q;
    stray_d       = stray_q;

    case (state_q)
      S_RST_REQ: if (RDY_server_reset_request_put) state_d = S_RST_RSP;
      S_RST_RSP: if (RDY_server_reset_response_get) state_d = S_IDLE;
      S_IDLE: begin
        // An accepted command takes priority over a same-cycle reinit request.
        if (cmd_valid) begin
          req_opcode_d = cmd_opcode;
          req_f7_d     = cmd_f7;
          req_rm_d     = cmd_rm;
          req_rs2_d    = cmd_rs2;
          req_v1_d     = cmd_v1;
          req_v2_d     = cmd_v2;
          req_v3_d     = cmd_v3;
          tag_d        = cmd_tag;
          state_d      = S_ISSUE;
        end else if (fbox_reinit) begin
          state_d = S_RST_REQ;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (valid) begin
          rsp_data_d    = word_fst;
          rsp_fflags_d  = word_snd;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d    = '0;
          rsp_fflags_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_RST_REQ;
    endcase

    if (valid && (state_q != S_WAIT)) stray_d = sat_inc(stray_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_RST_REQ;
      cnt_q         <= '0;
      req_opcode_q  <= '0;
      req_f7_q      <= '0;
      req_rm_q      <= '0;
      req_rs2_q     <= '0;
      req_v1_q      <= '0;
      req_v2_q      <= '0;
      req_v3_q      <= '0;
      tag_q         <= '0;
      rsp_data_q    <= '0;
      rsp_fflags_q  <= '0;
      rsp_timeout_q <= 1'b0;
      stray_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_opcode_q  <= req_opcode_d;
      req_f7_q      <= req_f7_d;
      req_rm_q      <= req_rm_d;
      req_rs2_q     <= req_rs2_d;
      req_v1_q      <= req_v1_d;
      req_v2_q      <= req_v2_d;
      req_v3_q      <= req_v3_d;
      tag_q         <= tag_d;
      rsp_data_q    <= rsp_data_d;
      rsp_fflags_q  <= rsp_fflags_d;
      rsp_timeout_q <= rsp_timeout_d;
      stray_q       <= stray_d;
    end
  end

  // RST gates the put strobe so every output is low while reset is held.
  assign EN_server_reset_request_put  = (state_q == S_RST_REQ) && RDY_server_reset_request_put && !RST;
  assign EN_server_reset_response_get = (state_q == S_RST_RSP) && RDY_server_reset_response_get;
  assign init_done   = (state_q == S_IDLE) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT) || (state_q == S_RESP);
  assign cmd_ready   = (state_q == S_IDLE);
  assign EN_req      = (state_q == S_ISSUE);
  assign rsp_valid   = (state_q == S_RESP);
  assign req_opcode  = req_opcode_q;
  assign req_f7      = req_f7_q;
  assign req_rm      = req_rm_q;
  assign req_rs2     = req_rs2_q;
  assign req_v1      = req_v1_q;
  assign req_v2      = req_v2_q;
  assign req_v3      = req_v3_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_fflags  = rsp_fflags_q;
  assign rsp_tag     = tag_q;
  assign rsp_timeout = rsp_timeout_q;
  assign stray_cnt   = stray_q;

endmodule

// File: tb/tb_fbox_issue_ctrl.sv
// Scoreboard bench for fbox_issue_ctrl: expected responses are queued when a command
// is driven and compared when the controller presents rsp_valid.
module tb_fbox_issue_ctrl;
  localparam int TAG_W = 4;
  localparam int TO    = 64;
  localparam int CNT_W = 8;

  logic CLK = 1'b0;
  logic RST;
  logic fbox_reinit, init_done, cmd_valid, cmd_ready;
  logic [6:0] cmd_opcode, cmd_f7;
  logic [2:0] cmd_rm;
  logic [4:0] cmd_rs2;
  logic [63:0] cmd_v1, cmd_v2, cmd_v3;
  logic [TAG_W-1:0] cmd_tag;
  logic EN_put, RDY_put, EN_get, RDY_get, EN_req;
  logic [6:0] req_opcode, req_f7;
  logic [2:0] req_rm;
  logic [4:0] req_rs2;
  logic [63:0] req_v1, req_v2, req_v3;
  logic valid;
  logic [63:0] word_fst;
  logic [4:0] word_snd;
  logic rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [4:0] rsp_fflags;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_timeout;
  logic [CNT_W-1:0] stray_cnt;

  typedef struct {
    logic [63:0]      data;
    logic [4:0]       ff;
    logic [TAG_W-1:0] tag;
    logic             to;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  fbox_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .fbox_reinit(fbox_reinit), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_f7(cmd_f7), .cmd_rm(cmd_rm), .cmd_rs2(cmd_rs2),
    .cmd_v1(cmd_v1), .cmd_v2(cmd_v2), .cmd_v3(cmd_v3), .cmd_tag(cmd_tag),
    .EN_server_reset_request_put(EN_put), .RDY_server_reset_request_put(RDY_put),
    .EN_server_reset_response_get(EN_get), .RDY_server_reset_response_get(RDY_get),
    .EN_req(EN_req), .req_opcode(req_opcode), .req_f7(req_f7), .req_rm(req_rm),
    .req_rs2(req_rs2), .req_v1(req_v1), .req_v2(req_v2), .req_v3(req_v3),
    .valid(valid), .word_fst(word_fst), .word_snd(word_snd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fflags(rsp_fflags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .stray_cnt(stray_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Counts handshake strobes until init_done rises (bounded).
  task automatic do_init();
    int puts = 0;
    int gets = 0;
    bit done = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      puts += int'(EN_put);
      gets += int'(EN_get);
      if (init_done) begin
        done = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("init_done", 64'(done), 64'd1);
    chk("init_put_pulses", 64'(puts), 64'd1);
    chk("init_get_pulses", 64'(gets), 64'd1);
    chk("init_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  // delay < 0: FBox never answers; otherwise valid is seen in WAIT cycle 'delay'.
  task automatic run_cmd(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] rm,
                         input logic [4:0] rs2, input logic [63:0] v1, input logic [63:0] v2,
                         input logic [63:0] v3, input logic [TAG_W-1:0] tag, input int delay,
                         input logic [63:0] res, input logic [4:0] ff, input int bp,
                         input bit reinit);
    exp_t e;
    int lat = 0;
    bit seen = 0;
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        seen = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("cmd_ready_wait", 64'(seen), 64'd1);
    cmd_opcode = op; cmd_f7 = f7; cmd_rm = rm; cmd_rs2 = rs2;
    cmd_v1 = v1; cmd_v2 = v2; cmd_v3 = v3; cmd_tag = tag;
    cmd_valid = 1'b1;
    fbox_reinit = reinit;
    rsp_ready = (bp == 0);
    if (delay < 0) e = '{data: 64'd0, ff: 5'd0, tag: tag, to: 1'b1};
    else           e = '{data: res, ff: ff, tag: tag, to: 1'b0};
    sb.push_back(e);
    @(negedge CLK);
    cmd_valid = 1'b0;
    fbox_reinit = 1'b0;
    chk("en_req_pulse", 64'(EN_req), 64'd1);
    chk("issue_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("issue_init_done", 64'(init_done), 64'd1);
    chk("req_opcode", 64'(req_opcode), 64'(op));
    chk("req_f7", 64'(req_f7), 64'(f7));
    chk("req_rm", 64'(req_rm), 64'(rm));
    chk("req_rs2", 64'(req_rs2), 64'(rs2));
    chk("req_v1", req_v1, v1);
    chk("req_v2", req_v2, v2);
    chk("req_v3", req_v3, v3);
    seen = 0;
    for (int c = 1; c <= TO + 10; c++) begin
      @(negedge CLK);
      if (c == 1) chk("en_req_single", 64'(EN_req), 64'd0);
      if (rsp_valid) begin
        seen = 1;
        lat = c;
        break;
      end
      valid = (delay >= 0) && (c == delay + 1);
      if (valid) begin
        word_fst = res;
        word_snd = ff;
      end
    end
    valid = 1'b0;
    chk("rsp_seen", 64'(seen), 64'd1);
    chk("rsp_latency", 64'(lat), (delay < 0) ? 64'(TO + 1) : 64'(delay + 2));
    if (seen) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_fflags", 64'(rsp_fflags), 64'(e.ff));
        chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        for (int i = 0; i < bp; i++) begin
          @(negedge CLK);
          chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
          chk("bp_rsp_data", rsp_data, e.data);
          chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
      end
      rsp_ready = 1'b1;
      @(negedge CLK);
      chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; fbox_reinit = 1'b0; cmd_valid = 1'b0;
    cmd_opcode = '0; cmd_f7 = '0; cmd_rm = '0; cmd_rs2 = '0;
    cmd_v1 = '0; cmd_v2 = '0; cmd_v3 = '0; cmd_tag = '0;
    RDY_put = 1'b1; RDY_get = 1'b1; valid = 1'b0; word_fst = '0; word_snd = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_en_put", 64'(EN_put), 64'd0);
    chk("rst_en_get", 64'(EN_get), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_en_req", 64'(EN_req), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_stray", 64'(stray_cnt), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    RST = 1'b0;
    do_init();

    // Basic add, then backpressure, then timeout.
    run_cmd(7'b1010011, 7'd0, 3'd0, 5'd0, 64'h42AA4000, 64'h42AA4000, 64'd0, 4'd3,
            3, 64'h432A4000, 5'd0, 0, 1'b0);
    run_cmd(7'b1010011, 7'h08, 3'd1, 5'd2, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
            64'h1, 4'd5, 0, 64'h4000_0000_0000_0000, 5'b00001, 10, 1'b0);
    word_fst = 64'hFFFF_0000_FFFF_0000; word_snd = 5'h1F;
    run_cmd(7'b1000011, 7'h01, 3'd7, 5'd31, 64'hA5, 64'h5A, 64'hC3, 4'd7,
            -1, 64'd0, 5'd0, 0, 1'b0);

    // Late FBox answer after the timeout counts as stray.
    @(negedge CLK);
    valid = 1'b1; word_fst = 64'hDEAD_BEEF;
    @(negedge CLK);
    valid = 1'b0;
    chk("stray_after_timeout", 64'(stray_cnt), 64'd1);
    chk("stray_no_rsp", 64'(rsp_valid), 64'd0);

    // Valid lands in the final WAIT cycle: data wins over timeout.
    run_cmd(7'b1010011, 7'h04, 3'd2, 5'd0, 64'h11, 64'h22, 64'h33, 4'd9,
            TO - 1, 64'h1234_5678_9ABC_DEF0, 5'b10000, 0, 1'b0);
    // Command accepted together with reinit: reinit is dropped.
    run_cmd(7'b1010011, 7'h0C, 3'd4, 5'd1, 64'h77, 64'h88, 64'h99, 4'd12,
            1, 64'hCAFE_F00D_0000_0001, 5'b00100, 0, 1'b1);

    // Reinit from IDLE, with the put side initially not ready.
    @(negedge CLK);
    RDY_put = 1'b0; fbox_reinit = 1'b1;
    @(negedge CLK);
    fbox_reinit = 1'b0;
    chk("reinit_init_done", 64'(init_done), 64'd0);
    chk("reinit_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reinit_put_gated", 64'(EN_put), 64'd0);
    @(negedge CLK);
    chk("reinit_stall", 64'(init_done), 64'd0);
    RDY_put = 1'b1;
    do_init();

    // Async reset while waiting on the FBox.
    @(negedge CLK);
    cmd_opcode = 7'b1010011; cmd_tag = 4'd5; cmd_v1 = 64'h5555; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("abort_en_req", 64'(EN_req), 64'd1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_en_req_low", 64'(EN_req), 64'd0);
    chk("abort_en_put", 64'(EN_put), 64'd0);
    chk("abort_init_done", 64'(init_done), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_opcode", 64'(req_opcode), 64'd0);
    chk("abort_req_v1", req_v1, 64'd0);
    chk("abort_rsp_data", rsp_data, 64'd0);
    chk("abort_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("abort_stray", 64'(stray_cnt), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    do_init();
    chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge CLK);
    valid = 1'b1;
    @(negedge CLK);
    valid = 1'b0;
    chk("late_valid_stray", 64'(stray_cnt), 64'd1);
    chk("late_valid_no_rsp", 64'(rsp_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
